// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter: registered one-hot grant held until done, request drop or hold timeout.
// Search starts just below the previous owner and wraps downward, so the last owner goes last.
module rr_priority_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_i,
    input  logic             done_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             timeout_o
);

    localparam int unsigned HoldW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic               rel_done, rel_drop, rel_limit, release_now;

    // Descending search: last-1, last-2, ..., wrapping, ending at last itself.
    always_comb begin
        int unsigned cand;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned j = 1; j <= N; j++) begin
            cand = (int'(last_q) + N - j) % N;
            if (!win_found && req_i[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    assign rel_done    = done_i;
    assign rel_drop    = !req_i[gnt_idx_q];
    assign rel_limit   = (MAX_HOLD != 0) && (hold_cnt_q == HoldW'(MAX_HOLD));
    assign release_now = rel_done || rel_drop || rel_limit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            last_q      <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (win_found)   state_d = StGrant;
            StGrant: if (release_now) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    gnt_idx_d      = win_idx;
                    gnt_valid_d    = 1'b1;
                    last_d         = win_idx;
                    hold_cnt_d     = HoldW'(1);
                end else begin
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                end
            end
            StGrant: begin
                if (release_now) begin
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    // Timeout flags only a release forced purely by the hold limit.
                    timeout_d   = rel_limit && !rel_done && !rel_drop;
                end else if (!rel_limit) begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end
            end
            default: begin
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_valid_o = gnt_valid_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for rr_priority_arbiter (N=8, MAX_HOLD=16) with hand-computed expectations.
module tb_rr_priority_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_tests;
    int n_fail;

    rr_priority_arbiter #(
        .N        (8),
        .IDX_W    (3),
        .MAX_HOLD (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .done_i      (done),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid),
        .timeout_o   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        step();
        step();
        n_tests++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL reset_gnt: got %h want 00", gnt); end
        n_tests++; if (gnt_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", gnt_idx); end
        n_tests++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        rst_n = 1'b1;
        step();
        n_tests++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL idle_no_req: got %h want 00", gnt); end
    endtask

    task automatic test_basic_grant();
        req = 8'h81;
        step();
        n_tests++; if (gnt !== 8'h80) begin n_fail++; $display("FAIL t1_gnt: got %h want 80", gnt); end
        n_tests++; if (gnt_idx !== 3'd7) begin n_fail++; $display("FAIL t1_idx: got %0d want 7", gnt_idx); end
        n_tests++; if (gnt_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid: got %b want 1", gnt_valid); end
        done = 1'b1;
        step();
        done = 1'b0;
        n_tests++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL t1_gap: got %h want 00", gnt); end
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL t1_gap_timeout: got %b want 0", timeout); end
        step();
        n_tests++; if (gnt !== 8'h01) begin n_fail++; $display("FAIL t1_gnt2: got %h want 01", gnt); end
        n_tests++; if (gnt_idx !== 3'd0) begin n_fail++; $display("FAIL t1_idx2: got %0d want 0", gnt_idx); end
        n_tests++; if (gnt_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid2: got %b want 1", gnt_valid); end
        req = 8'h00;
        step();
        step();
    endtask

    // last=0 here, so a full request vector rotates 7 down to 0 and wraps.
    task automatic test_rotation();
        int exp_order[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        logic [7:0] exp_gnt;
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            exp_gnt = 8'h01 << exp_order[i];
            n_tests++;
            if (gnt !== exp_gnt || gnt_idx !== 3'(exp_order[i]) || gnt_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL t2_grant%0d: got gnt=%h idx=%0d valid=%b want gnt=%h idx=%0d valid=1",
                         i, gnt, gnt_idx, gnt_valid, exp_gnt, exp_order[i]);
            end
            done = 1'b1;
            step();
            done = 1'b0;
            n_tests++;
            if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL t2_gap%0d: got gnt=%h valid=%b timeout=%b want 00/0/0",
                         i, gnt, gnt_valid, timeout);
            end
        end
        req = 8'h00;
        step();
        step();
    endtask

    task automatic test_timeout();
        int held;
        req = 8'h08;
        step();
        held = 0;
        for (int i = 0; i < 20; i++) begin
            if (gnt === 8'h08) held++;
            else break;
            step();
        end
        n_tests++; if (held != 16) begin n_fail++; $display("FAIL t3_hold_cycles: got %0d want 16", held); end
        n_tests++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL t3_release: got %h want 00", gnt); end
        n_tests++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL t3_timeout: got %b want 1", timeout); end
        step();
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL t3_timeout_pulse: got %b want 0", timeout); end
        n_tests++; if (gnt !== 8'h08) begin n_fail++; $display("FAIL t3_regrant: got %h want 08", gnt); end
        req = 8'h00;
        step();
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL t3_drop_timeout: got %b want 0", timeout); end
        step();
    endtask

    task automatic test_req_drop();
        req = 8'h20;
        step();
        n_tests++; if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin n_fail++; $display("FAIL t4_gnt: got %h idx=%0d want 20 idx=5", gnt, gnt_idx); end
        req = 8'h21; // other bits must not disturb the grant
        step();
        step();
        step();
        n_tests++; if (gnt !== 8'h20) begin n_fail++; $display("FAIL t4_stable: got %h want 20", gnt); end
        req = 8'h00;
        step();
        n_tests++; if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin n_fail++; $display("FAIL t4_release: got %h valid=%b want 00/0", gnt, gnt_valid); end
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL t4_timeout: got %b want 0", timeout); end
        step();
    endtask

    task automatic test_async_reset();
        req = 8'h20;
        step();
        n_tests++; if (gnt !== 8'h20) begin n_fail++; $display("FAIL t5_pre_gnt: got %h want 20", gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL t5_rst_gnt: got %h want 00", gnt); end
        n_tests++; if (gnt_idx !== 3'd0) begin n_fail++; $display("FAIL t5_rst_idx: got %0d want 0", gnt_idx); end
        n_tests++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL t5_rst_valid: got %b want 0", gnt_valid); end
        req   = 8'h24;
        rst_n = 1'b1;
        step();
        n_tests++; if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin n_fail++; $display("FAIL t5_post_gnt: got %h idx=%0d want 20 idx=5", gnt, gnt_idx); end
        req = 8'h00;
        step();
        step();
    endtask

    task automatic test_done_corner();
        done = 1'b1;
        step();
        n_tests++; if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin n_fail++; $display("FAIL t6_idle_done: got %h valid=%b want 00/0", gnt, gnt_valid); end
        req = 8'h08;
        step();
        done = 1'b0;
        n_tests++; if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin n_fail++; $display("FAIL t6_grant_with_done: got %h idx=%0d want 08 idx=3", gnt, gnt_idx); end
        for (int i = 2; i <= 16; i++) step();
        n_tests++; if (gnt !== 8'h08) begin n_fail++; $display("FAIL t6_last_cycle: got %h want 08", gnt); end
        done = 1'b1;
        step();
        done = 1'b0;
        n_tests++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL t6_release: got %h want 00", gnt); end
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL t6_timeout: got %b want 0", timeout); end
        req = 8'h00;
        step();
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req     = '0;
        done    = 1'b0;
        test_reset();
        test_basic_grant();
        test_rotation();
        test_timeout();
        test_req_drop();
        test_async_reset();
        test_done_corner();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
